// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch controller and its queue.
package mips_fetch_pkg;

    localparam int          WORD_BYTES       = 4;
    localparam int          INSTR_WIDTH      = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        FULL    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]            pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_controller_fetch_queue.sv
// Synchronous instruction FIFO. Flush beats push; a pop during flush still counts as consumed.
module fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [CW-1:0] count_q;
    logic          pop_ok;
    logic          push_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push_ok = push_i && !flush_i && ((count_q != CW'(DEPTH)) || pop_ok);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= push_entry_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_q <= rd_q + AW'(1);
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_controller.sv
// Fetch sequencer: owns the PC, issues word requests, buffers returns, handles redirects.
// Define IFETCH_FAULT_EN to trap misaligned redirects (sticky FetchFault, fetch halts).
module instruction_fetch_controller
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic        MemReq,
    output logic [31:0] MemAddress,
    input  logic        MemAck,
    input  logic [31:0] MemData,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instruction,
    output logic [31:0] InstrPC,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectPC,
    output logic        FetchFault
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   pc_q, pc_d;
    logic          push;
    logic          flush;
    logic          pop_ok;
    logic          redir;
    logic          bad_redir;
    logic [31:0]   target;
    logic [CW-1:0] count;
    logic [CW-1:0] cnt_next;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;

`ifdef IFETCH_FAULT_EN
    logic fault_q, fault_d;

    assign redir     = RedirectValid && !fault_q;
    assign bad_redir = redir && (RedirectPC[1:0] != 2'b00);
    assign target    = RedirectPC;
    assign fault_d   = fault_q || bad_redir;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    logic fault_q;

    assign fault_q   = 1'b0;
    assign redir     = RedirectValid;
    assign bad_redir = 1'b0;
    assign target    = RedirectPC & ~32'h3;
`endif

    assign pop_ok     = InstrReady && InstrValid;
    assign push_entry = '{pc: pc_q, instr: MemData};

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        addr_d   = addr_q;
        pc_d     = pc_q;
        push     = 1'b0;
        flush    = 1'b0;
        cnt_next = count;
        if (redir) begin
            flush = 1'b1;
            if (!bad_redir) begin
                pc_d = target;
            end
            // An unanswered request must stay on the bus; its data is dropped later.
            if (req_q && !MemAck) begin
                state_d = DISCARD;
            end else begin
                state_d = FETCH;
                req_d   = !(fault_q || bad_redir);
                addr_d  = pc_d;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (req_q && MemAck) begin
                        push = 1'b1;
                        pc_d = pc_q + 32'(WORD_BYTES);
                    end
                    cnt_next = count + CW'(push) - CW'(pop_ok);
                    if (!(req_q && !MemAck)) begin
                        if ((cnt_next < CW'(QUEUE_DEPTH)) && !fault_q) begin
                            req_d  = 1'b1;
                            addr_d = pc_d;
                        end else begin
                            req_d   = 1'b0;
                            state_d = fault_q ? FETCH : FULL;
                        end
                    end
                end
                FULL: begin
                    if (pop_ok) begin
                        state_d = FETCH;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                    end
                end
                DISCARD: begin
                    if (MemAck) begin
                        state_d = FETCH;
                        req_d   = !fault_q;
                        addr_d  = pc_q;
                    end
                end
                default: begin
                    state_d = FETCH;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= FETCH;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
        end
    end

    fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk_i       (Clock),
        .rst_i       (Reset),
        .push_i      (push),
        .push_entry_i(push_entry),
        .pop_i       (InstrReady),
        .flush_i     (flush),
        .head_o      (head),
        .count_o     (count)
    );

    assign MemReq      = req_q;
    assign MemAddress  = addr_q;
    assign InstrValid  = (count != '0);
    assign Instruction = head.instr;
    assign InstrPC     = head.pc;
    assign FetchFault  = fault_q;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Bench for instruction_fetch_controller: directed scenarios plus random traffic vs a queue model.
module tb_instruction_fetch_controller;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
`ifdef IFETCH_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        MemReq;
    logic [31:0] MemAddress;
    logic        MemAck = 1'b0;
    logic [31:0] MemData = '0;
    logic        InstrValid;
    logic        InstrReady = 1'b0;
    logic [31:0] Instruction;
    logic [31:0] InstrPC;
    logic        RedirectValid = 1'b0;
    logic [31:0] RedirectPC = '0;
    logic        FetchFault;

    always #5 Clock = ~Clock;

    instruction_fetch_controller #(
        .RESET_PC   (RESET_PC),
        .QUEUE_DEPTH(DEPTH)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .MemReq       (MemReq),
        .MemAddress   (MemAddress),
        .MemAck       (MemAck),
        .MemData      (MemData),
        .InstrValid   (InstrValid),
        .InstrReady   (InstrReady),
        .Instruction  (Instruction),
        .InstrPC      (InstrPC),
        .RedirectValid(RedirectValid),
        .RedirectPC   (RedirectPC),
        .FetchFault   (FetchFault)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    int          total = 0;
    int          bad   = 0;
    ent_t        m_q[$];
    logic        m_req;
    logic [31:0] m_addr;
    logic [31:0] m_pc;
    bit          m_discard;
    bit          m_fault;
    bit          live = 1'b0;
    int          mem_lat = 0;
    int          wait_cnt = 0;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[17:2], ~a[17:2]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        if (!live) return;
        chk("mem_req", MemReq, m_req);
        if (m_req) chk("mem_addr", MemAddress, m_addr);
        chk("instr_valid", InstrValid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            chk("instr_pc", InstrPC, m_q[0].pc);
            chk("instruction", Instruction, m_q[0].instr);
        end
        chk("fetch_fault", FetchFault, m_fault);
    endtask

    // Advance the reference model by one clock using the inputs driven this cycle.
    task automatic model_step();
        bit ack;
        bit redir;
        if (Reset) begin
            m_q.delete();
            m_req = 1'b0; m_addr = RESET_PC; m_pc = RESET_PC;
            m_discard = 1'b0; m_fault = 1'b0; live = 1'b1;
            return;
        end
        ack = m_req && MemAck;
        if (InstrReady && m_q.size() > 0) void'(m_q.pop_front());
        redir = RedirectValid && !m_fault;
        if (redir) begin
            m_q.delete();
            if (FAULT_EN && (RedirectPC[1:0] != 2'b00)) m_fault = 1'b1;
            else m_pc = RedirectPC & ~32'h3;
            if (m_req && !MemAck) begin
                m_discard = 1'b1;
            end else begin
                m_discard = 1'b0; m_req = !m_fault; m_addr = m_pc;
            end
        end else if (m_discard) begin
            if (ack) begin
                m_discard = 1'b0; m_req = !m_fault; m_addr = m_pc;
            end
        end else begin
            if (ack) begin
                m_q.push_back('{pc: m_addr, instr: rom_word(m_addr)});
                m_pc = m_addr + 32'd4;
            end
            if (!(m_req && !MemAck)) begin
                if (m_q.size() < DEPTH && !m_fault) begin
                    m_req = 1'b1; m_addr = m_pc;
                end else begin
                    m_req = 1'b0;
                end
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit rdy, input bit rv, input logic [31:0] rpc);
        @(negedge Clock);
        model_check();
        Reset = rst; InstrReady = rdy; RedirectValid = rv; RedirectPC = rpc;
        if (MemReq && !rst) begin
            if (wait_cnt >= mem_lat) begin
                MemAck = 1'b1; MemData = rom_word(MemAddress); wait_cnt = 0;
            end else begin
                MemAck = 1'b0; MemData = $urandom; wait_cnt++;
            end
        end else begin
            MemAck = 1'b0; MemData = $urandom; wait_cnt = 0;
        end
        model_step();
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        bit          found;
        logic [31:0] r;
        bit          rdy, rv, rst;

        // Zero-wait stream with decode always ready.
        mem_lat = 0;
        do_reset();
        chk("rst_memreq", MemReq, 1'b0);
        chk("rst_memaddr", MemAddress, RESET_PC);
        chk("rst_valid", InstrValid, 1'b0);
        chk("rst_instr", Instruction, 32'h0);
        chk("rst_instrpc", InstrPC, 32'h0);
        chk("rst_fault", FetchFault, 1'b0);
        cycle(0, 1, 0, 0);
        chk("c0_memreq", MemReq, 1'b0);
        cycle(0, 1, 0, 0);
        chk("c1_memreq", MemReq, 1'b1);
        chk("c1_addr", MemAddress, 32'h0);
        chk("c1_valid", InstrValid, 1'b0);
        cycle(0, 1, 0, 0);
        chk("c2_valid", InstrValid, 1'b1);
        chk("c2_pc", InstrPC, 32'h0);
        chk("c2_instr", Instruction, rom_word(32'h0));
        chk("c2_addr", MemAddress, 32'h4);
        cycle(0, 1, 0, 0);
        chk("c3_pc", InstrPC, 32'h4);
        chk("c3_addr", MemAddress, 32'h8);
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0);

        // Backpressure: queue fills, requests stop, resume after first pop.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
        chk("full_memreq", MemReq, 1'b0);
        chk("full_valid", InstrValid, 1'b1);
        chk("full_pc", InstrPC, 32'h0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        chk("resume_memreq", MemReq, 1'b1);
        chk("resume_addr", MemAddress, 32'h8);
        chk("resume_pc", InstrPC, 32'h4);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0);

        // Slow memory, redirect while 0x0C is outstanding.
        do_reset();
        mem_lat = 3;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            cycle(0, 1, 0, 0);
            if (MemReq && MemAddress == 32'h0C) found = 1'b1;
        end
        chk("find_0c", found, 1'b1);
        cycle(0, 1, 1, 32'h14);
        chk("held_req", MemReq, 1'b1);
        chk("held_addr", MemAddress, 32'h0C);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(0, 1, 0, 0);
            if (MemAddress != 32'h0C) found = 1'b1;
        end
        chk("discard_done", found, 1'b1);
        chk("redir_addr", MemAddress, 32'h14);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(0, 1, 0, 0);
            if (InstrValid) found = 1'b1;
        end
        chk("redir_delivered", found, 1'b1);
        chk("redir_first_pc", InstrPC, 32'h14);

        // Redirect on a full queue with a simultaneous pop.
        do_reset();
        mem_lat = 0;
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
        chk("full2_pc", InstrPC, 32'h0);
        cycle(0, 1, 1, 32'h40);
        cycle(0, 1, 0, 0);
        chk("flush_valid", InstrValid, 1'b0);
        chk("flush_req", MemReq, 1'b1);
        chk("flush_addr", MemAddress, 32'h40);
        cycle(0, 1, 0, 0);
        chk("after_flush_valid", InstrValid, 1'b1);
        chk("after_flush_pc", InstrPC, 32'h40);

        // PC wrap at the top of the address space.
        cycle(0, 1, 1, 32'hFFFF_FFF8);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle(0, 1, 0, 0);
            if (MemReq && MemAddress == 32'hFFFF_FFFC) found = 1'b1;
        end
        chk("find_top", found, 1'b1);
        cycle(0, 1, 0, 0);
        chk("wrap_addr", MemAddress, 32'h0);

        // Misaligned redirect.
        cycle(0, 1, 1, 32'h16);
        cycle(0, 1, 0, 0);
`ifdef IFETCH_FAULT_EN
        chk("fault_set", FetchFault, 1'b1);
        chk("fault_noreq", MemReq, 1'b0);
        cycle(0, 1, 1, 32'h100);
        cycle(0, 1, 0, 0);
        chk("fault_sticky", FetchFault, 1'b1);
        chk("fault_ignore_redir", MemReq, 1'b0);
        chk("fault_empty", InstrValid, 1'b0);
        do_reset();
        chk("fault_cleared", FetchFault, 1'b0);
`else
        chk("misal_addr", MemAddress, 32'h14);
        chk("misal_nofault", FetchFault, 1'b0);
        cycle(0, 1, 0, 0);
        chk("misal_pc", InstrPC, 32'h14);
`endif

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (wait_cnt == 0) mem_lat = $urandom_range(0, 3);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 299) == 0);
            r = $urandom;
            if ($urandom_range(0, 5) != 0) r[1:0] = 2'b00;
            cycle(rst, rdy, rv, r);
        end
        cycle(0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
